// File: rtl/wbh_reg_bridge_if.sv
// Bus bundle for wbh_reg_bridge: Wishbone slave side plus register-bus master side.
// The slave modport is the bridge view; the master modport is the surrounding system.
interface wbh_reg_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [4:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        reg_cs;
    logic        reg_wr;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  reg_rdata, reg_ack,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output reg_rdata, reg_ack,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
    );
endinterface

// File: rtl/wbh_reg_bridge.sv
// Wishbone-to-register-bus bridge: one outstanding transfer, registered outputs.
// Define WBH_REG_TIMEOUT_EN to add the WAIT timeout counter and bus-error response.
module wbh_reg_bridge #(
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_0BAD
) (
    input  logic             mclk,
    input  logic             p_reset_n,
    wbh_reg_bridge_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        unused_s;

`ifdef WBH_REG_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    // Next-state and output computation for the transfer FSM.
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
`ifdef WBH_REG_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    wr_d    = bus.wbs_we_i;
                    addr_d  = bus.wbs_adr_i[4:2];
                    wdata_d = bus.wbs_dat_i;
                    be_d    = bus.wbs_sel_i;
                    cs_d    = 1'b1;
`ifdef WBH_REG_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // An abort outranks a coincident ack: the master has already left.
                if (!bus.wbs_cyc_i) begin
                    cs_d    = 1'b0;
                    state_d = IDLE;
                end else if (bus.reg_ack) begin
                    cs_d    = 1'b0;
                    ack_d   = 1'b1;
                    if (!wr_q) begin
                        dat_d = bus.reg_rdata;
                    end else begin
                        dat_d = dat_q;
                    end
                    state_d = DONE;
`ifdef WBH_REG_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    cs_d    = 1'b0;
                    err_d   = 1'b1;
                    dat_d   = ERR_RDATA;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = WAIT;
                end
`else
                end else begin
                    state_d = WAIT;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                cs_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops with asynchronous clear.
    always_ff @(posedge mclk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state_q <= IDLE;
            dat_q   <= 32'd0;
            ack_q   <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 3'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

`ifdef WBH_REG_TIMEOUT_EN
    // Timeout counter and error pulse flops.
    always_ff @(posedge mclk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.wbs_err_o = err_q;
    assign unused_s      = ^bus.wbs_adr_i[1:0];
`else
    assign bus.wbs_err_o = 1'b0;
    assign unused_s      = ^{bus.wbs_adr_i[1:0], ERR_RDATA, TIMEOUT_CYC};
`endif

    assign bus.wbs_dat_o = dat_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.reg_cs    = cs_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_be    = be_q;

endmodule
